ct_spsram_128x144_ctrl: RTL and testbench



---
 rtl/ct_spsram_128x144_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ct_spsram_128x144_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_spsram_128x144_ctrl.sv
// ct_spsram_128x144_ctrl
// Access controller for the 128x144 single-port data SRAM. After reset, or
// when init_start is pulsed, it sweeps the whole array with zero writes. In
// normal operation it round-robin arbitrates two requesters onto the single
// SRAM port, registers every SRAM control signal, and returns read data
// tagged with the requester that issued the read.
module ct_spsram_128x144_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 144,
  parameter int DEPTH      = 128
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  init_start,
  output logic                  init_busy,
  input  logic                  req0_vld,
  input  logic                  req0_wr,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [DATA_WIDTH-1:0] req0_wmask,
  output logic                  req0_gnt,
  input  logic                  req1_vld,
  input  logic                  req1_wr,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic [DATA_WIDTH-1:0] req1_wmask,
  output logic                  req1_gnt,
  output logic                  rdata_vld,
  output logic                  rdata_id,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  sram_cen_b,
  output logic                  sram_gwen_b,
  output logic [DATA_WIDTH-1:0] sram_wen_b,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   init_cnt;
  logic                    rr_ptr;
  logic                    rd_pend;
  logic                    rd_pend_id;

  logic                    gnt0;
  logic                    gnt1;
  logic                    gnt_any;
  logic                    sel_wr;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [DATA_WIDTH-1:0]   sel_wmask;

  // Round-robin grant: a lone requester always wins, a tie goes to rr_ptr;
  // nothing is granted during the sweep or in the cycle init_start is seen.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == RUN && !init_start) begin
      if (req0_vld && req1_vld) begin
        gnt0 = ~rr_ptr;
        gnt1 = rr_ptr;
      end else begin
        gnt0 = req0_vld;
        gnt1 = req1_vld;
      end
    end
  end

  // Mux the winning request's fields onto the SRAM issue path.
  always_comb begin
    gnt_any   = gnt0 | gnt1;
    sel_wr    = gnt1 ? req1_wr    : req0_wr;
    sel_addr  = gnt1 ? req1_addr  : req0_addr;
    sel_wdata = gnt1 ? req1_wdata : req0_wdata;
    sel_wmask = gnt1 ? req1_wmask : req0_wmask;
  end

  assign req0_gnt = gnt0;
  assign req1_gnt = gnt1;

  // SRAM Q is only meaningful the cycle after a read, so it is passed
  // straight through and zeroed whenever no read is being returned.
  assign rdata = rdata_vld ? sram_dout : '0;

  // Read-return pipeline: pending flag in the SRAM access cycle, valid the
  // cycle after, when Q is available. Survives init_start, cleared by reset.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_pend    <= 1'b0;
      rd_pend_id <= 1'b0;
      rdata_vld  <= 1'b0;
      rdata_id   <= 1'b0;
    end else begin
      rd_pend    <= gnt_any & ~sel_wr;
      rd_pend_id <= gnt1;
      rdata_vld  <= rd_pend;
      if (rd_pend) begin
        rdata_id <= rd_pend_id;
      end
    end
  end

  // Control FSM: init sweep / run, round-robin pointer and registered SRAM
  // interface.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state       <= INIT;
      init_cnt    <= '0;
      rr_ptr      <= 1'b0;
      init_busy   <= 1'b1;
      sram_cen_b  <= 1'b1;
      sram_gwen_b <= 1'b1;
      sram_wen_b  <= '1;
      sram_addr   <= '0;
      sram_din    <= '0;
    end else begin
      case (state)
        INIT: begin
          sram_cen_b  <= 1'b0;
          sram_gwen_b <= 1'b0;
          sram_wen_b  <= '0;
          sram_din    <= '0;
          sram_addr   <= init_cnt;
          if (init_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            init_cnt  <= '0;
            state     <= RUN;
            init_busy <= 1'b0;
          end else begin
            init_cnt  <= init_cnt + 1'b1;
          end
        end
        RUN: begin
          if (init_start) begin
            state       <= INIT;
            init_busy   <= 1'b1;
            sram_cen_b  <= 1'b1;
            sram_gwen_b <= 1'b1;
            sram_wen_b  <= '1;
          end else if (gnt_any) begin
            // Pointer always moves to the requester that did not win.
            rr_ptr      <= gnt0;
            sram_cen_b  <= 1'b0;
            sram_addr   <= sel_addr;
            if (sel_wr) begin
              sram_gwen_b <= 1'b0;
              sram_wen_b  <= ~sel_wmask;
              sram_din    <= sel_wdata;
            end else begin
              sram_gwen_b <= 1'b1;
              sram_wen_b  <= '1;
              sram_din    <= '0;
            end
          end else begin
            sram_cen_b  <= 1'b1;
            sram_gwen_b <= 1'b1;
            sram_wen_b  <= '1;
          end
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ct_spsram_128x144_ctrl.sv
// Directed testbench for ct_spsram_128x144_ctrl with a behavioural
// bit-maskable SRAM model attached to the SRAM port.
module tb_ct_spsram_128x144_ctrl;

  localparam int AW    = 7;
  localparam int DW    = 144;
  localparam int NENT  = 128;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          init_start;
  logic          init_busy;
  logic          req0_vld, req0_wr, req0_gnt;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, req0_wmask;
  logic          req1_vld, req1_wr, req1_gnt;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, req1_wmask;
  logic          rdata_vld, rdata_id;
  logic [DW-1:0] rdata;
  logic          sram_cen_b, sram_gwen_b;
  logic [DW-1:0] sram_wen_b, sram_din;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dout;

  logic [DW-1:0] mem [NENT];
  logic [DW-1:0] all1;
  logic [DW-1:0] b143;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ct_spsram_128x144_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (NENT)
  ) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_b),
    .init_start     (init_start),
    .init_busy      (init_busy),
    .req0_vld       (req0_vld),
    .req0_wr        (req0_wr),
    .req0_addr      (req0_addr),
    .req0_wdata     (req0_wdata),
    .req0_wmask     (req0_wmask),
    .req0_gnt       (req0_gnt),
    .req1_vld       (req1_vld),
    .req1_wr        (req1_wr),
    .req1_addr      (req1_addr),
    .req1_wdata     (req1_wdata),
    .req1_wmask     (req1_wmask),
    .req1_gnt       (req1_gnt),
    .rdata_vld      (rdata_vld),
    .rdata_id       (rdata_id),
    .rdata          (rdata),
    .sram_cen_b     (sram_cen_b),
    .sram_gwen_b    (sram_gwen_b),
    .sram_wen_b     (sram_wen_b),
    .sram_addr      (sram_addr),
    .sram_din       (sram_din),
    .sram_dout      (sram_dout)
  );

  // SRAM model: bit-masked write, Q registered one cycle after a read.
  always @(posedge clk) begin
    if (!sram_cen_b) begin
      if (!sram_gwen_b) begin
        mem[sram_addr] = (mem[sram_addr] & sram_wen_b) | (sram_din & ~sram_wen_b);
      end else begin
        sram_dout <= mem[sram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_cen_b", DW'(sram_cen_b), DW'(1));
    chk("rst_gwen_b", DW'(sram_gwen_b), DW'(1));
    chk("rst_wen_b", sram_wen_b, all1);
    chk("rst_addr", DW'(sram_addr), DW'(0));
    chk("rst_din", sram_din, '0);
    chk("rst_init_busy", DW'(init_busy), DW'(1));
    chk("rst_rdata_vld", DW'(rdata_vld), DW'(0));
    chk("rst_rdata_id", DW'(rdata_id), DW'(0));
    chk("rst_rdata", rdata, '0);
  endtask

  // Called at the first cycle whose SRAM registers show the addr-0 write;
  // both requesters are held valid to prove nothing is granted.
  task automatic sweep();
    for (int k = 0; k < NENT; k++) begin
      chk("init_cen_b", DW'(sram_cen_b), DW'(0));
      chk("init_gwen_b", DW'(sram_gwen_b), DW'(0));
      chk("init_wen_b", sram_wen_b, '0);
      chk("init_addr", DW'(sram_addr), DW'(k));
      chk("init_din", sram_din, '0);
      chk("init_busy", DW'(init_busy), (k == NENT - 1) ? DW'(0) : DW'(1));
      if (k == NENT - 1) begin
        req0_vld = 1'b0;
        req1_vld = 1'b0;
      end else begin
        req0_vld = 1'b1;
        req1_vld = 1'b1;
        #1;
        chk("init_gnt0", DW'(req0_gnt), DW'(0));
        chk("init_gnt1", DW'(req1_gnt), DW'(0));
      end
      step();
    end
    chk("post_init_cen_b", DW'(sram_cen_b), DW'(1));
  endtask

  initial begin
    all1 = '1;
    b143 = '0;
    b143[143] = 1'b1;
    for (int i = 0; i < NENT; i++) mem[i] = '1;
    sram_dout  = '0;
    rst_b      = 1'b0;
    init_start = 1'b0;
    req0_vld = 1'b0; req0_wr = 1'b0; req0_addr = '0; req0_wdata = '0; req0_wmask = '0;
    req1_vld = 1'b0; req1_wr = 1'b0; req1_addr = '0; req1_wdata = '0; req1_wmask = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    req0_vld = 1'b1;
    #1;
    chk("rst_gnt0", DW'(req0_gnt), DW'(0));
    req0_vld = 1'b0;

    // Power-up sweep
    rst_b = 1'b1;
    step();
    sweep();

    // req0 write addr 5, then read it back
    req0_vld = 1'b1; req0_wr = 1'b1; req0_addr = 7'd5;
    req0_wdata = 144'hA5; req0_wmask = 144'hFF;
    #1;
    chk("wr_gnt0", DW'(req0_gnt), DW'(1));
    chk("wr_gnt1", DW'(req1_gnt), DW'(0));
    step();
    chk("wr_cen_b", DW'(sram_cen_b), DW'(0));
    chk("wr_gwen_b", DW'(sram_gwen_b), DW'(0));
    chk("wr_wen_b", sram_wen_b, ~(144'hFF));
    chk("wr_addr", DW'(sram_addr), DW'(5));
    chk("wr_din", sram_din, 144'hA5);
    req0_wr = 1'b0;
    #1;
    chk("rd_gnt0", DW'(req0_gnt), DW'(1));
    step();
    req0_vld = 1'b0;
    chk("rd_cen_b", DW'(sram_cen_b), DW'(0));
    chk("rd_gwen_b", DW'(sram_gwen_b), DW'(1));
    chk("rd_wen_b", sram_wen_b, all1);
    chk("rd_addr", DW'(sram_addr), DW'(5));
    chk("rd_din", sram_din, '0);
    chk("rd_vld_early", DW'(rdata_vld), DW'(0));
    step();
    chk("rd_vld", DW'(rdata_vld), DW'(1));
    chk("rd_data", rdata, 144'hA5);
    chk("rd_id", DW'(rdata_id), DW'(0));

    // req1 partial write: bit 143 only into cleared entry 7
    req1_vld = 1'b1; req1_wr = 1'b1; req1_addr = 7'd7;
    req1_wdata = all1; req1_wmask = b143;
    #1;
    chk("pw_gnt1", DW'(req1_gnt), DW'(1));
    chk("pw_gnt0", DW'(req0_gnt), DW'(0));
    step();
    req1_vld = 1'b0;
    chk("pw_vld_off", DW'(rdata_vld), DW'(0));
    chk("pw_rdata_zero", rdata, '0);
    chk("pw_cen_b", DW'(sram_cen_b), DW'(0));
    chk("pw_gwen_b", DW'(sram_gwen_b), DW'(0));
    chk("pw_wen_b", sram_wen_b, ~b143);
    chk("pw_din", sram_din, all1);
    chk("pw_addr", DW'(sram_addr), DW'(7));
    step();
    chk("idle_cen_b", DW'(sram_cen_b), DW'(1));
    chk("idle_addr_hold", DW'(sram_addr), DW'(7));
    chk("idle_din_hold", sram_din, all1);
    step();

    // Both requesters held valid for 4 cycles from pointer 0
    req0_wr = 1'b0; req0_addr = 7'd5;
    req1_wr = 1'b0; req1_addr = 7'd7;
    for (int i = 0; i < 6; i++) begin
      if (i >= 1 && i <= 4) begin
        chk("rr_cen_b", DW'(sram_cen_b), DW'(0));
        chk("rr_gwen_b", DW'(sram_gwen_b), DW'(1));
        chk("rr_addr", DW'(sram_addr), ((i - 1) % 2 == 0) ? DW'(5) : DW'(7));
      end
      if (i >= 2) begin
        chk("rr_vld", DW'(rdata_vld), DW'(1));
        chk("rr_id", DW'(rdata_id), DW'((i - 2) % 2));
        chk("rr_data", rdata, ((i - 2) % 2 == 0) ? 144'hA5 : b143);
      end
      if (i == 5) chk("rr_idle_cen_b", DW'(sram_cen_b), DW'(1));
      if (i < 4) begin
        req0_vld = 1'b1;
        req1_vld = 1'b1;
        #1;
        chk("rr_gnt0", DW'(req0_gnt), DW'(i % 2 == 0));
        chk("rr_gnt1", DW'(req1_gnt), DW'(i % 2 == 1));
      end else begin
        req0_vld = 1'b0;
        req1_vld = 1'b0;
      end
      step();
    end
    chk("rr_vld_off", DW'(rdata_vld), DW'(0));

    // init_start while a req1 read is in flight
    req1_vld = 1'b1; req1_wr = 1'b0; req1_addr = 7'd5;
    #1;
    chk("is_gnt1", DW'(req1_gnt), DW'(1));
    step();
    req1_vld = 1'b0;
    chk("is_rd_addr", DW'(sram_addr), DW'(5));
    init_start = 1'b1;
    req0_vld = 1'b1; req0_wr = 1'b0;
    #1;
    chk("is_gnt0_supp", DW'(req0_gnt), DW'(0));
    chk("is_gnt1_supp", DW'(req1_gnt), DW'(0));
    step();
    init_start = 1'b0;
    chk("is_rd_vld", DW'(rdata_vld), DW'(1));
    chk("is_rd_id", DW'(rdata_id), DW'(1));
    chk("is_rd_data", rdata, 144'hA5);
    chk("is_busy", DW'(init_busy), DW'(1));
    chk("is_cen_b", DW'(sram_cen_b), DW'(1));
    #1;
    chk("is_gnt0_init", DW'(req0_gnt), DW'(0));
    step();
    sweep();

    // Entry 5 was cleared by the re-sweep
    req0_vld = 1'b1; req0_wr = 1'b0; req0_addr = 7'd5;
    #1;
    chk("clr_gnt0", DW'(req0_gnt), DW'(1));
    step();
    req0_vld = 1'b0;
    step();
    chk("clr_vld", DW'(rdata_vld), DW'(1));
    chk("clr_data", rdata, '0);
    chk("clr_id", DW'(rdata_id), DW'(0));

    // Reset asserted mid-sweep at counter 60
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    step();
    for (int j = 0; j < 60; j++) begin
      chk("mid_addr", DW'(sram_addr), DW'(j));
      if (j < 59) step();
    end
    #2;
    rst_b = 1'b0;
    #1;
    chk_reset_vals();
    step();
    chk("mid_rst_addr", DW'(sram_addr), DW'(0));
    rst_b = 1'b1;
    step();
    sweep();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
